// File: rtl/sub_iter_pkg.sv
// Shared types and sizing helpers for the iterative borrow-propagation subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH = 8;

    // Width of a counter that can hold 0..width inclusive.
    function automatic int sub_iters_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sub_iter_step.sv
// One borrow-propagation step: XOR the borrow into the difference, then
// regenerate the borrow from bits where a 0 had a borrow applied.
module sub_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] x_next,
    output logic [WIDTH-1:0] b_next,
    output logic             msb_borrow
);

    logic [WIDTH-1:0] gen;

    always_comb begin
        gen        = ~x & b;
        x_next     = x ^ b;
        b_next     = {gen[WIDTH-2:0], 1'b0};
        msb_borrow = gen[WIDTH-1];
    end

endmodule

// File: rtl/sub_iter.sv
// Sequential iterative subtractor: op1 - op2 by one borrow step per clock,
// with valid/ready handshakes on both the operand and result sides.
//
//   state | meaning
//   IDLE  | ready for a new operand pair
//   ITER  | applying borrow steps until the borrow word is zero
//   DONE  | result presented, waiting for out_ready
module sub_iter
    import sub_pkg::*;
#(
    parameter int WIDTH   = SUB_WIDTH,
    parameter int ITERS_W = sub_iters_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Diff,
    output logic               borrow_out,
    output logic [ITERS_W-1:0] iters
);

    sub_state_t         state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               bo_q, bo_d;
    logic [ITERS_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]   step_x;
    logic [WIDTH-1:0]   step_b;
    logic               step_msb;

    sub_step #(.WIDTH(WIDTH)) u_step (
        .x          (x_q),
        .b          (b_q),
        .x_next     (step_x),
        .b_next     (step_b),
        .msb_borrow (step_msb)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        b_d     = b_q;
        bo_d    = bo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = op1;
                    b_d     = op2;
                    bo_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                // The borrow word shifts left every step, so cnt tops out at WIDTH.
                if (b_q != '0) begin
                    x_d   = step_x;
                    b_d   = step_b;
                    bo_d  = bo_q | step_msb;
                    cnt_d = cnt_q + ITERS_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            b_q     <= '0;
            bo_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            b_q     <= b_d;
            bo_q    <= bo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        Diff       = x_q;
        borrow_out = bo_q;
        iters      = cnt_q;
    end

endmodule

// File: doc/sub_iter.md
# sub_iter

Sequential iterative subtractor; the inverse of the team's XOR/AND carry-iteration adder. Computes `op1 - op2` by repeated borrow propagation (`diff ^= brw; brw = (~diff & brw) << 1`), one step per clock, until the borrow word is zero. Operands arrive and results leave on valid/ready handshakes. The block feeds the cross-bar datapath wherever a difference or an unsigned compare is needed.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset: synchronous, active-low, sampled on `clk` rising edge.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `op1`  in  WIDTH  minuend, unsigned.
- `op2`  in  WIDTH  subtrahend, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `Diff`  out  WIDTH  `(op1 - op2) mod 2^WIDTH`.
- `borrow_out`  out  1  1 iff `op1 < op2` (unsigned).
- `iters`  out  $clog2(WIDTH+1)  number of borrow steps performed (0..WIDTH).

## Operation
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `x <= op1`, `b <= op2`, `bo <= 0`, `cnt <= 0`; go to ITER.
- ITER, while `b != 0`:
  - `x <= x ^ b`
  - `b <= ((~x & b) << 1)` truncated to WIDTH.
  - `bo <= bo | (~x & b)[WIDTH-1]`.
  - `cnt <= cnt + 1`.
- ITER, `b == 0`: go to DONE; no register update.
- DONE:
  - `out_valid` = 1; `Diff` = `x`, `borrow_out` = `bo`, `iters` = `cnt`; all held stable while `out_ready` = 0.
  - On `out_ready`: go to IDLE.
- `in_ready` = 0 in ITER and DONE; operands presented then are ignored, not queued.
- Step count never exceeds WIDTH: the borrow word shifts left every step, so it is zero after at most WIDTH steps. `cnt` cannot overflow.
- Arithmetic is modulo `2^WIDTH`; there is no signed interpretation.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - State = IDLE; `x`, `b`, `bo`, `cnt` = 0.
  - Outputs: `in_ready` = 1, `out_valid` = 0, `Diff` = 0, `borrow_out` = 0, `iters` = 0.
  - Reset overrides any state, including mid-ITER and DONE; an in-flight result is discarded with no output.
- Latency, for k = number of borrow steps, with the accept edge as edge 0:
  - `out_valid` rises after edge k+1.
  - `op2` = 0 gives `out_valid` after edge 1.
- Handshakes:
  - Result transfer occurs at the edge where `out_valid && out_ready`. `in_ready` returns 1 in the following cycle.
  - Minimum initiation interval is k+3 cycles.
  - `out_valid` is a registered-state decode, with no combinational path from `in_valid`/`out_ready`.
  - `in_ready` depends only on state.
- `out_ready` held high before DONE: the transfer takes place at the first DONE cycle.

## Structure
- `sub_pkg`:
  - state enum `sub_state_t` {IDLE, ITER, DONE}.
  - default `SUB_WIDTH` = 8.
  - function `sub_iters_w(WIDTH)` returning $clog2(WIDTH+1).
- Sub-module `sub_step`: combinational, one borrow step.
  - Inputs: `x`, `b`.
  - Outputs: `x_next`, `b_next`, `msb_borrow`.
  - Keeps the FSM file to registers and control only.
- Total RTL: roughly 150–200 lines.

## Test plan
- Basic subtract: accept `op1`=5, `op2`=3, `out_ready`=1 → `Diff`=2, `borrow_out`=0, `iters`=2, `out_valid` after edge 3.
- Worst case: `op1`=0, `op2`=1 → `Diff`=0xFF, `borrow_out`=1, `iters`=8, `out_valid` after edge 9.
- Zero subtrahend: `op1`=7, `op2`=0 → `Diff`=7, `borrow_out`=0, `iters`=0, `out_valid` after edge 1.
- Backpressure: `op1`=0x80, `op2`=0x81, `out_ready`=0 for 5 cycles in DONE.
  - `Diff`=0xFF, `borrow_out`=1, all outputs stable throughout, `in_ready`=0.
  - New `in_valid` pulses are ignored.
  - Release `out_ready` → IDLE the next cycle.
- Reset mid-ITER: accept 0−1, assert `rst_n`=0 at edge 3 → next cycle `out_valid`=0, `in_ready`=1, `Diff`=0.
  - Then 9−4 completes with `Diff`=5.
- Random sweep: 1000 random operand pairs with random `out_ready` gaps.
  - Every result matches `(op1-op2) mod 256` and `op1<op2`.
  - `iters` ≤ 8 for every result.
